// File: rtl/mc_control_fsm_pkg.sv
// Shared types for the multicycle MIPS main control: state encoding, opcodes,
// mux/ALU select codes and the registered control word.
package mc_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       halted;
    } mc_ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the main control FSM (master) and the
// datapath/memory it sequences (slave).
interface mc_control_fsm_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_re;
    logic               mem_we;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               halted;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero,
        output mem_re, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               halted, state
    );

    modport slave (
        output opcode, zero,
        input  mem_re, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               halted, state
    );
endinterface

// File: rtl/mc_control_fsm_out_decode.sv
// Purely combinational state -> control word lookup; every field defaults to 0
// and each state lists only what it asserts.
module mc_out_decode
    import mc_pkg::*;
(
    input  mc_state_e i_state,
    output mc_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_re    = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_ONE;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_BRIMM;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = SRCA_REG;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.mem_re = 1'b1;
                o_ctrl.iord   = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_we = 1'b1;
                o_ctrl.iord   = 1'b1;
            end
            S_RTYPE_EX: begin
                o_ctrl.alu_src_a = SRCA_REG;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_EX: begin
                o_ctrl.alu_src_a = SRCA_REG;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = SRCA_REG;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PC_SRC_JUMP;
            end
            S_HALT: begin
                o_ctrl.halted = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM. Optional bne support under `MC_BNE_EN.
//
// state      | meaning
// FETCH      | read instruction at PC into IR, PC <= PC + 1
// DECODE     | ALUOut <= PC + 1 + imm, dispatch on opcode
// MEMADR     | ALUOut <= A + imm (lw/sw address)
// MEMRD      | read data memory at ALUOut
// MEMWB      | rt <= MDR
// MEMWR      | write B to memory at ALUOut (single cycle)
// RTYPE_EX   | ALU A funct B
// RTYPE_WB   | rd <= ALUOut
// ADDI_EX    | ALU A + imm
// ADDI_WB    | rt <= ALUOut
// BRANCH     | compare A - B, conditional PC <= ALUOut
// JUMP       | PC <= {PC[31:26], IR[25:0]}
// HALT       | undecoded opcode with ILLEGAL_HALT, wait for rst
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    mc_control_fsm_if.master  bus
);

    mc_state_e r_state;
    mc_state_e w_next_state;
    mc_state_e w_state_d;
    mc_ctrl_t  r_ctrl;
    mc_ctrl_t  w_ctrl_d;
`ifdef MC_BNE_EN
    logic      r_is_bne;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_RTYPE_EX;
                    OP_ADDI:      w_next_state = S_ADDI_EX;
                    OP_BEQ:       w_next_state = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next_state = S_BRANCH;
`endif
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWR:    w_next_state = S_FETCH;
            S_RTYPE_EX: w_next_state = S_RTYPE_WB;
            S_RTYPE_WB: w_next_state = S_FETCH;
            S_ADDI_EX:  w_next_state = S_ADDI_WB;
            S_ADDI_WB:  w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JUMP:     w_next_state = S_FETCH;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
        // Outputs are registered, so the decode looks at the state being entered.
        w_state_d = rst ? S_FETCH : w_next_state;
    end

    mc_out_decode u_out_decode (
        .i_state (w_state_d),
        .o_ctrl  (w_ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
`ifdef MC_BNE_EN
            r_is_bne <= 1'b0;
`endif
        end else begin
            r_state  <= w_next_state;
`ifdef MC_BNE_EN
            if (r_state == S_DECODE) begin
                r_is_bne <= (bus.opcode == OP_BNE);
            end
`endif
        end
        r_ctrl <= w_ctrl_d;
    end

    assign bus.mem_re     = r_ctrl.mem_re;
    assign bus.mem_we     = r_ctrl.mem_we;
    assign bus.iord       = r_ctrl.iord;
    assign bus.ir_write   = r_ctrl.ir_write;
    assign bus.pc_write   = r_ctrl.pc_write;
    assign bus.pc_src     = r_ctrl.pc_src;
    assign bus.alu_src_a  = r_ctrl.alu_src_a;
    assign bus.alu_src_b  = r_ctrl.alu_src_b;
    assign bus.alu_op     = r_ctrl.alu_op;
    assign bus.reg_write  = r_ctrl.reg_write;
    assign bus.reg_dst    = r_ctrl.reg_dst;
    assign bus.mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.halted     = r_ctrl.halted;
    assign bus.state      = STATE_W'(r_state);

`ifdef MC_BNE_EN
    // Branch outcome resolved here so the datapath sees a plain PC load.
    assign bus.pc_write_cond = r_ctrl.pc_write_cond & (bus.zero ^ r_is_bne);
`else
    assign bus.pc_write_cond = r_ctrl.pc_write_cond;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: expected state/control words are queued
// per instruction and compared cycle by cycle on the falling edge.
module tb_mc_control_fsm;
    import mc_pkg::*;

    typedef struct {
        mc_state_e   st;
        logic [16:0] ctl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_h;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mc_control_fsm_if #(.STATE_W(4)) bus   ();
    mc_control_fsm_if #(.STATE_W(4)) bus_h ();

    mc_control_fsm #(.STATE_W(4), .ILLEGAL_HALT(1'b0)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    mc_control_fsm #(.STATE_W(4), .ILLEGAL_HALT(1'b1)) dut_h (
        .clk (clk), .rst (rst_h), .bus (bus_h)
    );

    // {mem_re, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
    //  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted}
    function automatic logic [16:0] spec_ctrl(mc_state_e st, logic z, logic bne);
        logic re, we, iord, irw, pcw, pcwc, sa, rw, rd, m2r, h;
        logic [1:0] ps, sb2, op;
        {re, we, iord, irw, pcw, pcwc, sa, rw, rd, m2r, h} = '0;
        ps = 2'b00; sb2 = 2'b00; op = 2'b00;
        case (st)
            S_FETCH:    begin re = 1; irw = 1; pcw = 1; sb2 = 2'b01; end
            S_DECODE:   sb2 = 2'b11;
            S_MEMADR:   begin sa = 1; sb2 = 2'b10; end
            S_MEMRD:    begin re = 1; iord = 1; end
            S_MEMWB:    begin rw = 1; m2r = 1; end
            S_MEMWR:    begin we = 1; iord = 1; end
            S_RTYPE_EX: begin sa = 1; op = 2'b10; end
            S_RTYPE_WB: begin rw = 1; rd = 1; end
            S_ADDI_EX:  begin sa = 1; sb2 = 2'b10; end
            S_ADDI_WB:  rw = 1;
            S_BRANCH: begin
                sa = 1; op = 2'b01; ps = 2'b01;
`ifdef MC_BNE_EN
                pcwc = z ^ bne;
`else
                pcwc = 1'b1;
`endif
            end
            S_JUMP:     begin pcw = 1; ps = 2'b10; end
            S_HALT:     h = 1;
            default:    ;
        endcase
        return {re, we, iord, irw, pcw, pcwc, ps, sa, sb2, op, rw, rd, m2r, h};
    endfunction

    function automatic logic [16:0] obs_main();
        return {bus.mem_re, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.halted};
    endfunction

    function automatic logic [16:0] obs_halt();
        return {bus_h.mem_re, bus_h.mem_we, bus_h.iord, bus_h.ir_write, bus_h.pc_write,
                bus_h.pc_write_cond, bus_h.pc_src, bus_h.alu_src_a, bus_h.alu_src_b,
                bus_h.alu_op, bus_h.reg_write, bus_h.reg_dst, bus_h.mem_to_reg, bus_h.halted};
    endfunction

    // Expected state sequence of one instruction, starting in FETCH.
    task automatic push_instr(input logic [5:0] op, input logic z);
        mc_state_e seq[$];
        logic bne;
        bne = (op == OP_BNE);
        seq = {S_FETCH, S_DECODE};
        case (op)
            OP_LW:    seq = {seq, S_MEMADR, S_MEMRD, S_MEMWB};
            OP_SW:    seq = {seq, S_MEMADR, S_MEMWR};
            OP_RTYPE: seq = {seq, S_RTYPE_EX, S_RTYPE_WB};
            OP_ADDI:  seq = {seq, S_ADDI_EX, S_ADDI_WB};
            OP_BEQ:   seq.push_back(S_BRANCH);
`ifdef MC_BNE_EN
            OP_BNE:   seq.push_back(S_BRANCH);
`endif
            OP_J:     seq.push_back(S_JUMP);
            default:  ;
        endcase
        foreach (seq[i]) sb.push_back('{st: seq[i], ctl: spec_ctrl(seq[i], z, bne)});
    endtask

    // Pops the scoreboard one cycle at a time; opcode is only meaningful in
    // DECODE/MEMADR, so it is scrambled everywhere else. With stop_n > 0 it
    // returns right after checking entry stop_n without advancing the clock.
    task automatic scoreboard_drain(input logic [5:0] op, input string tag, input int stop_n);
        exp_t e;
        int   len;
        len = (stop_n > 0) ? stop_n : sb.size();
        for (int i = 0; i < len; i++) begin
            e = sb.pop_front();
            if (e.st == S_DECODE || e.st == S_MEMADR) bus.opcode = op;
            else bus.opcode = 6'($urandom);
            #1;
            checks++;
            if (bus.state !== 4'(e.st)) begin
                errors++;
                $display("FAIL %s[%0d] state got %0d want %0d", tag, i, bus.state, e.st);
            end
            checks++;
            if (obs_main() !== e.ctl) begin
                errors++;
                $display("FAIL %s[%0d] ctrl got %b want %b", tag, i, obs_main(), e.ctl);
            end
            checks++;
            if (bus.mem_re === 1'b1 && bus.mem_we === 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] mem_re_we got 11 want not both", tag, i);
            end
            if (i < len - 1 || stop_n <= 0) @(negedge clk);
        end
        sb.delete();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input string tag);
        bus.zero = z;
        push_instr(op, z);
        scoreboard_drain(op, tag, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = OP_SW;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.state !== 4'(S_FETCH) || bus.mem_re !== 1'b1 || bus.ir_write !== 1'b1 ||
            bus.pc_write !== 1'b1) begin
            errors++;
            $display("FAIL reset state=%0d re=%b irw=%b pcw=%b want 0 1 1 1",
                     bus.state, bus.mem_re, bus.ir_write, bus.pc_write);
        end
        checks++;
        if (obs_main() !== spec_ctrl(S_FETCH, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", obs_main(), spec_ctrl(S_FETCH, 1'b0, 1'b0));
        end
    endtask

    task automatic test_lw_sw();
        run_instr(OP_LW, 1'b0, "lw");
        run_instr(OP_SW, 1'b1, "sw");
    endtask

    task automatic test_alu_ops();
        run_instr(OP_RTYPE, 1'b0, "rtype");
        run_instr(OP_ADDI, 1'b1, "addi");
    endtask

    task automatic test_branch_jump();
        run_instr(OP_BEQ, 1'b1, "beq_z1");
        run_instr(OP_BEQ, 1'b0, "beq_z0");
        run_instr(OP_J, 1'b0, "jump");
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 1'b0, "illegal_3f");
        run_instr(OP_BNE, 1'b0, "op05_z0");
        run_instr(OP_BNE, 1'b1, "op05_z1");
    endtask

    task automatic test_reset_mid_sw();
        bus.zero = 1'b0;
        push_instr(OP_SW, 1'b0);
        scoreboard_drain(OP_SW, "sw_pre_rst", 4);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'(S_FETCH) || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_sw state=%0d mem_we=%b want 0 0", bus.state, bus.mem_we);
        end
        checks++;
        if (obs_main() !== spec_ctrl(S_FETCH, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL rst_mid_sw_ctrl got %b want %b", obs_main(), spec_ctrl(S_FETCH, 1'b0, 1'b0));
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8];
        ops = '{OP_LW, OP_RTYPE, OP_SW, OP_ADDI, OP_BEQ, OP_J, 6'h3F, OP_LW};
        foreach (ops[i]) run_instr(ops[i], 1'($urandom), $sformatf("b2b%0d", i));
    endtask

    task automatic test_halt();
        mc_state_e seq[$];
        exp_t e;
        bus_h.opcode = 6'h3F;
        bus_h.zero = 1'b0;
        seq = {S_FETCH, S_DECODE};
        repeat (12) seq.push_back(S_HALT);
        foreach (seq[i]) sb.push_back('{st: seq[i], ctl: spec_ctrl(seq[i], 1'b0, 1'b0)});
        @(negedge clk);
        rst_h = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus_h.state !== 4'(e.st) || obs_halt() !== e.ctl) begin
                errors++;
                $display("FAIL halt state=%0d ctrl=%b want %0d %b", bus_h.state, obs_halt(), e.st, e.ctl);
            end
            @(negedge clk);
        end
        rst_h = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_h.state !== 4'(S_FETCH) || bus_h.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit state=%0d halted=%b want 0 0", bus_h.state, bus_h.halted);
        end
        rst_h = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_h.state !== 4'(S_DECODE)) begin
            errors++;
            $display("FAIL halt_restart state=%0d want %0d", bus_h.state, S_DECODE);
        end
    endtask

    initial begin
        rst_h = 1'b1;
        bus_h.opcode = 6'h00;
        bus_h.zero = 1'b0;
        test_reset();
        test_lw_sw();
        test_alu_ops();
        test_branch_jump();
        test_illegal();
        test_reset_mid_sw();
        test_back_to_back();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
